// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Access sequencer states: arbitrate, drive the RAM, wait for read data.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } state_e;

  // Grant identifiers; also the bit positions in the request vector.
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. The last-grant history lives
// in the parent so this block stays purely combinational.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_valid = |req;
    gnt_id    = GNT_CPU;
    if (req == 2'b11) begin
      gnt_id = ~last_grant;
    end else if (req[GNT_DMA]) begin
      gnt_id = GNT_DMA;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read single-port data RAM between the CPU MEM-stage
// port and a DMA/loader port. One transaction is captured per arbitration,
// sequenced onto the RAM, and completed with a one-cycle ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,

  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [31:0]       dma_addr,
  input  logic [31:0]       dma_wdata,
  output logic [31:0]       dma_rdata,
  output logic              dma_ack,

  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e              state_q, state_d;
  logic                last_grant_q;
  logic                g_id_q;
  logic                g_we_q;
  logic [ADDR_W-1:0]   g_addr_q;
  logic [31:0]         g_wdata_q;
  logic [31:0]         cpu_rdata_q;
  logic [31:0]         dma_rdata_q;

  logic                gnt_valid;
  logic                gnt_id;
  logic                capture;
  logic                sel_we;
  logic [31:0]         sel_addr;
  logic [31:0]         sel_wdata;
  logic                done;

  // Byte-offset bits and address bits above the RAM are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2],
                              dma_addr[1:0], dma_addr[31:ADDR_W+2]};

  rr_arb2 u_rr_arb2 (
    .req        ({dma_req, cpu_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Steer the winning port's request fields toward the capture registers.
  always_comb begin
    sel_we    = cpu_we;
    sel_addr  = cpu_addr;
    sel_wdata = cpu_wdata;
    if (gnt_id == GNT_DMA) begin
      sel_we    = dma_we;
      sel_addr  = dma_addr;
      sel_wdata = dma_wdata;
    end
  end

  // Next-state logic: arbitrate only in IDLE, writes finish in ISSUE.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          capture = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = g_we_q ? IDLE : RWAIT;
      RWAIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, grant history and capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DMA;
      g_id_q       <= GNT_CPU;
      g_we_q       <= 1'b0;
      g_addr_q     <= '0;
      g_wdata_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      if (capture) begin
        last_grant_q <= gnt_id;
        g_id_q       <= gnt_id;
        g_we_q       <= sel_we;
        g_addr_q     <= sel_addr[ADDR_W+1:2];
        g_wdata_q    <= sel_wdata;
      end
    end
  end

  // Read-data holding registers; only the granted port's copy is updated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are plain registers, not a memory array, so resetting
      // them is cheap and gives a defined value before the first load.
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (state_q == RWAIT) begin
      if (g_id_q == GNT_CPU) cpu_rdata_q <= ram_rdata;
      else                   dma_rdata_q <= ram_rdata;
    end
  end

  // RAM strobes decode from the state so reset drops them asynchronously;
  // address and data come from the capture registers and so hold between
  // accesses.
  assign ram_en    = (state_q == ISSUE);
  assign ram_we    = ram_en & g_we_q;
  assign ram_addr  = g_addr_q;
  assign ram_wdata = g_wdata_q;

  // A write completes in ISSUE, a read in RWAIT.
  assign done    = (ram_en & g_we_q) | (state_q == RWAIT);
  assign cpu_ack = done & (g_id_q == GNT_CPU);
  assign dma_ack = done & (g_id_q == GNT_DMA);

  // Load data bypasses the holding register in the ack cycle so it is
  // valid while the ack is high, then the register keeps it.
  assign cpu_rdata = (state_q == RWAIT && g_id_q == GNT_CPU) ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = (state_q == RWAIT && g_id_q == GNT_DMA) ? ram_rdata : dma_rdata_q;

  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for contention and reset corner cases.
module tb_dmem_arbiter;

  localparam int ADDR_W = 14;

  logic              clk;
  logic              rst;
  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0]       cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [31:0]       cpu_rdata, dma_rdata;
  logic              cpu_ack, cpu_stall, dma_ack;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  int errors = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM model; known words are reloaded while rst is high.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (rst) begin
      mem[0]    <= 32'hA0A0_A0A0;
      mem[1]    <= 32'hB1B1_B1B1;
      mem[4]    <= 32'h1234_5678;
      mem[8]    <= 32'hCAFE_F00D;
      ram_rdata <= 32'h0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  typedef struct {
    logic        c_req, c_we;
    logic [31:0] c_addr, c_wd;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wd;
    logic        e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic        e_cack, e_dack, e_stall;
    logic [31:0] e_crd, e_drd;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
    input logic en, input logic we, input logic [31:0] ad, input logic [31:0] wd,
    input logic ck, input logic dk, input logic st,
    input logic [31:0] crd, input logic [31:0] drd);
    vec_t v;
    v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wd = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wd = dd;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_wd = wd;
    v.e_cack = ck; v.e_dack = dk; v.e_stall = st;
    v.e_crd = crd; v.e_drd = drd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Read word 4, write word 4, address change after capture, DMA read,
    // and a write whose upper address bits must be ignored.
    vecs[0]  = mk(1,0,32'h10,0, 0,0,0,0, 0,0,0,0, 0,0,1, 0,0);
    vecs[1]  = mk(1,0,32'h10,0, 0,0,0,0, 1,0,4,0, 0,0,1, 0,0);
    vecs[2]  = mk(1,0,32'h10,0, 0,0,0,0, 0,0,4,0, 1,0,0, 32'h12345678,0);
    vecs[3]  = mk(0,0,0,0,      0,0,0,0, 0,0,4,0, 0,0,0, 32'h12345678,0);
    vecs[4]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 0,0,4,0, 0,0,1, 32'h12345678,0);
    vecs[5]  = mk(1,1,32'h10,32'hDEADBEEF, 0,0,0,0, 1,1,4,32'hDEADBEEF, 1,0,0, 32'h12345678,0);
    vecs[6]  = mk(0,0,0,0,      0,0,0,0, 0,0,4,32'hDEADBEEF, 0,0,0, 32'h12345678,0);
    vecs[7]  = mk(1,0,32'h10,0, 0,0,0,0, 0,0,4,32'hDEADBEEF, 0,0,1, 32'h12345678,0);
    vecs[8]  = mk(1,0,32'h20,0, 0,0,0,0, 1,0,4,0, 0,0,1, 32'h12345678,0);
    vecs[9]  = mk(1,0,32'h20,0, 0,0,0,0, 0,0,4,0, 1,0,0, 32'hDEADBEEF,0);
    vecs[10] = mk(0,0,0,0,      0,0,0,0, 0,0,4,0, 0,0,0, 32'hDEADBEEF,0);
    vecs[11] = mk(0,0,0,0, 1,0,32'h20,0, 0,0,4,0, 0,0,0, 32'hDEADBEEF,0);
    vecs[12] = mk(0,0,0,0, 1,0,32'h20,0, 1,0,8,0, 0,0,0, 32'hDEADBEEF,0);
    vecs[13] = mk(0,0,0,0, 1,0,32'h20,0, 0,0,8,0, 0,1,0, 32'hDEADBEEF,32'hCAFEF00D);
    vecs[14] = mk(0,0,0,0, 0,0,0,0,      0,0,8,0, 0,0,0, 32'hDEADBEEF,32'hCAFEF00D);
    vecs[15] = mk(1,1,32'hFFFFFFFC,32'h55AA55AA, 0,0,0,0, 0,0,8,0, 0,0,1, 32'hDEADBEEF,32'hCAFEF00D);
    vecs[16] = mk(1,1,32'hFFFFFFFC,32'h55AA55AA, 0,0,0,0, 1,1,32'h3FFF,32'h55AA55AA, 1,0,0, 32'hDEADBEEF,32'hCAFEF00D);
    vecs[17] = mk(0,0,0,0, 0,0,0,0, 0,0,32'h3FFF,32'h55AA55AA, 0,0,0, 32'hDEADBEEF,32'hCAFEF00D);

    // Reset values, with cpu_stall following cpu_req during reset.
    rst = 1'b1;
    clear_inputs();
    cpu_req = 1'b1;
    @(negedge clk);
    #1;
    check("rst_stall",     32'(cpu_stall), 1);
    check("rst_ram_en",    32'(ram_en),    0);
    check("rst_ram_we",    32'(ram_we),    0);
    check("rst_ram_addr",  32'(ram_addr),  0);
    check("rst_ram_wdata", ram_wdata,      0);
    check("rst_acks",      32'({cpu_ack, dma_ack}), 0);
    check("rst_cpu_rdata", cpu_rdata,      0);
    check("rst_dma_rdata", dma_rdata,      0);
    cpu_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single-port sequences.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      cpu_req = vecs[i].c_req; cpu_we = vecs[i].c_we;
      cpu_addr = vecs[i].c_addr; cpu_wdata = vecs[i].c_wd;
      dma_req = vecs[i].d_req; dma_we = vecs[i].d_we;
      dma_addr = vecs[i].d_addr; dma_wdata = vecs[i].d_wd;
      #1;
      check($sformatf("vec%0d_ram_en", i),    32'(ram_en),    32'(vecs[i].e_en));
      check($sformatf("vec%0d_ram_we", i),    32'(ram_we),    32'(vecs[i].e_we));
      check($sformatf("vec%0d_ram_addr", i),  32'(ram_addr),  vecs[i].e_addr);
      check($sformatf("vec%0d_ram_wdata", i), ram_wdata,      vecs[i].e_wd);
      check($sformatf("vec%0d_cpu_ack", i),   32'(cpu_ack),   32'(vecs[i].e_cack));
      check($sformatf("vec%0d_dma_ack", i),   32'(dma_ack),   32'(vecs[i].e_dack));
      check($sformatf("vec%0d_cpu_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_cpu_rdata", i), cpu_rdata,      vecs[i].e_crd);
      check($sformatf("vec%0d_dma_rdata", i), dma_rdata,      vecs[i].e_drd);
    end

    // Simultaneous reads after reset: CPU first, DMA captured at N+3.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h0;
    dma_req = 1; dma_addr = 32'h4;
    for (int c = 0; c <= 5; c++) begin
      if (c == 3) cpu_req = 0;
      #1;
      case (c)
        1: begin
          check("sim_c1_ram_en",   32'(ram_en),   1);
          check("sim_c1_ram_addr", 32'(ram_addr), 0);
        end
        2: begin
          check("sim_c2_cpu_ack",   32'(cpu_ack), 1);
          check("sim_c2_dma_ack",   32'(dma_ack), 0);
          check("sim_c2_cpu_rdata", cpu_rdata,    32'hA0A0A0A0);
        end
        3: begin
          check("sim_c3_dma_ack", 32'(dma_ack), 0);
          check("sim_c3_ram_en",  32'(ram_en),  0);
        end
        4: begin
          check("sim_c4_ram_en",   32'(ram_en),   1);
          check("sim_c4_ram_addr", 32'(ram_addr), 1);
        end
        5: begin
          check("sim_c5_dma_ack",   32'(dma_ack), 1);
          check("sim_c5_cpu_ack",   32'(cpu_ack), 0);
          check("sim_c5_dma_rdata", dma_rdata,    32'hB1B1B1B1);
          check("sim_c5_cpu_rdata", cpu_rdata,    32'hA0A0A0A0);
        end
        default: ;
      endcase
      @(negedge clk);
    end
    clear_inputs();

    // Sustained contention: reads held on both ports for 12 cycles.
    do_reset();
    begin
      logic exp_owner;
      int   n_acks;
      exp_owner = 1'b0;
      n_acks    = 0;
      cpu_req = 1; cpu_addr = 32'h0;
      dma_req = 1; dma_addr = 32'h4;
      for (int c = 0; c < 12; c++) begin
        #1;
        check($sformatf("cont_c%0d_ack_slot", c), 32'(cpu_ack | dma_ack), 32'((c % 3) == 2));
        if (cpu_ack || dma_ack) begin
          check($sformatf("cont_c%0d_owner", c), 32'({cpu_ack, dma_ack}),
                exp_owner ? 32'b01 : 32'b10);
          exp_owner = ~exp_owner;
          n_acks++;
        end
        @(negedge clk);
      end
      check("cont_ack_count", 32'(n_acks), 4);
    end
    clear_inputs();

    // Reset asserted in RWAIT, then the held CPU read restarts.
    do_reset();
    cpu_req = 1; cpu_addr = 32'h10;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rmid_cpu_ack",   32'(cpu_ack),   0);
    check("rmid_ram_en",    32'(ram_en),    0);
    check("rmid_cpu_rdata", cpu_rdata,      0);
    check("rmid_dma_rdata", dma_rdata,      0);
    check("rmid_stall",     32'(cpu_stall), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rrel_c0_ram_en",  32'(ram_en),  0);
    check("rrel_c0_cpu_ack", 32'(cpu_ack), 0);
    @(negedge clk);
    #1;
    check("rrel_c1_ram_en",   32'(ram_en),   1);
    check("rrel_c1_ram_addr", 32'(ram_addr), 4);
    @(negedge clk);
    #1;
    check("rrel_c2_cpu_ack",   32'(cpu_ack), 1);
    check("rrel_c2_cpu_rdata", cpu_rdata,    32'h12345678);
    @(negedge clk);
    clear_inputs();
    #1;
    check("rrel_c3_cpu_ack",   32'(cpu_ack), 0);
    check("rrel_c3_cpu_rdata", cpu_rdata,    32'h12345678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
